// File: rtl/sha256_pad.sv
// sha256_pad: byte-stream message padder for the multi-chunk SHA-256 core.
// Collects up to MAX_BYTES message bytes and builds the padded buffer:
// 0x80 terminator, zero fill and the 64-bit big-endian bit length in the
// last 8 bytes of the final used chunk. Byte i of the message sits at
// str[MAX_CHUNKS*512-1-8*i -: 8].
// Optional feature macro: SHA256_PAD_ERR_EN adds the `error` overflow port.
module sha256_pad #(
  parameter int MAX_CHUNKS = 2,
  localparam int MAX_BYTES = 64 * MAX_CHUNKS - 9,
  localparam int NCW       = $clog2(MAX_CHUNKS) + 1,
  localparam int STR_W     = MAX_CHUNKS * 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             done,
  output logic [NCW-1:0]   num_chunks,
  output logic [STR_W-1:0] str
`ifdef SHA256_PAD_ERR_EN
  ,
  output logic             error
`endif
);

  // Count must hold MAX_BYTES+1 (saturation value marking a dropped byte).
  localparam int CW = $clog2(MAX_BYTES + 2);
  localparam logic [CW-1:0] MAX_B = CW'(MAX_BYTES);
  localparam logic [CW-1:0] SAT_B = CW'(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [STR_W-1:0] str_q;
  logic [NCW-1:0]   nc_q;
  logic             done_q;
  logic             rdy_q;
`ifdef SHA256_PAD_ERR_EN
  logic             drop_q;
  logic             err_q;
`endif

  logic [CW-1:0]  pad_len;
  logic [31:0]    pad_sum;
  logic [NCW-1:0] pad_nc;
  logic [63:0]    pad_bits;

  // Padding geometry for the FINISH step: clamped length, chunk count, bit length.
  always_comb begin
    pad_len  = (count_q > MAX_B) ? MAX_B : count_q;
    pad_sum  = 32'(pad_len) + 32'd72;
    pad_nc   = NCW'(pad_sum >> 6);
    pad_bits = {{(61 - CW){1'b0}}, pad_len, 3'b000};
  end

  // Job sequencer: clear, load bytes, pad, then hold results until start drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      str_q   <= '0;
      nc_q    <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef SHA256_PAD_ERR_EN
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b0;
          if (start && !done_q) begin
            state_q <= S_CLEAR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          str_q   <= '0;
          count_q <= '0;
          nc_q    <= '0;
`ifdef SHA256_PAD_ERR_EN
          drop_q  <= 1'b0;
          err_q   <= 1'b0;
`endif
          if (start) begin
            rdy_q   <= 1'b1;
            state_q <= S_LOAD;
          end else begin
            rdy_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (!start) begin
            rdy_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (in_valid) begin
            // Store in-range bytes; anything past MAX_BYTES is discarded.
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (count_q == CW'(i)) begin
                str_q[STR_W-1-8*i -: 8] <= in_data;
              end
            end
`ifdef SHA256_PAD_ERR_EN
            if (count_q >= MAX_B) begin
              drop_q <= 1'b1;
            end
`endif
            if (count_q != SAT_B) begin
              count_q <= count_q + CW'(1);
            end
            if (in_last) begin
              rdy_q   <= 1'b0;
              state_q <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          rdy_q <= 1'b0;
          if (!start) begin
            state_q <= S_IDLE;
          end else begin
            for (int i = 0; i <= MAX_BYTES; i++) begin
              if (pad_len == CW'(i)) begin
                str_q[STR_W-1-8*i -: 8] <= 8'h80;
              end
            end
            // Length field occupies the last 8 bytes of the final used chunk.
            for (int c = 1; c <= MAX_CHUNKS; c++) begin
              if (pad_nc == NCW'(c)) begin
                str_q[STR_W-512*c +: 64] <= pad_bits;
              end
            end
            nc_q    <= pad_nc;
            done_q  <= 1'b1;
`ifdef SHA256_PAD_ERR_EN
            err_q   <= drop_q;
`endif
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          rdy_q <= 1'b0;
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = rdy_q;
  assign done       = done_q;
  assign num_chunks = nc_q;
  assign str        = str_q;
`ifdef SHA256_PAD_ERR_EN
  assign error      = err_q;
`endif

endmodule
